// File: rtl/if_stage.sv
// if_stage: program counter, instruction ROM and IF/ID pipeline register with stall and redirect
module if_stage #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        Jump,
  input  logic [63:0] NewPC,
  output logic [63:0] PCNow,
  output logic [63:0] PCNext4,
  output logic [31:0] IFID_Instruction,
  output logic [63:0] IFID_PC,
  output logic [63:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic        MisalignedFault
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [63:0] IMEM_BYTES = 64'(4 * IMEM_DEPTH);
  // Standard image: word i is "addi x1, x0, i", so every fetched word identifies its own slot.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
    return {12'(idx), 20'h00093};
  endfunction
  logic [31:0] fetched;
  assign PCNext4 = PCNow + 64'd4;
  // Combinational ROM read; addresses past the ROM fetch a NOP.
  always_comb begin
    fetched = (PCNow >= IMEM_BYTES) ? NOP_INSTR : rom_word(PCNow[AW+1:2]);
  end
  // PC and IF/ID update: redirect flushes, PCWrite advances, otherwise hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PCNow            <= RESET_PC;
      IFID_Instruction <= NOP_INSTR;
      IFID_PC          <= 64'd0;
      IFID_PC4         <= 64'd0;
      IFID_Valid       <= 1'b0;
      MisalignedFault  <= 1'b0;
    end else if (Jump) begin
      PCNow            <= {NewPC[63:2], 2'b00};
      IFID_Instruction <= NOP_INSTR;
      IFID_PC          <= 64'd0;
      IFID_PC4         <= 64'd0;
      IFID_Valid       <= 1'b0;
      MisalignedFault  <= MisalignedFault | (|NewPC[1:0]);
    end else if (PCWrite) begin
      PCNow            <= PCNext4;
      IFID_Instruction <= fetched;
      IFID_PC          <= PCNow;
      IFID_PC4         <= PCNext4;
      IFID_Valid       <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector check of reset, fetch, stall, redirect, misalignment, async reset and wrap
module tb_if_stage;
  logic        Clk = 1'b0;
  logic        Reset, PCWrite, Jump;
  logic [63:0] NewPC;
  logic [63:0] PCNow, PCNext4, IFID_PC, IFID_PC4;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid, MisalignedFault;
  int n_tests = 0;
  int n_fail  = 0;
  localparam logic [31:0] NOP = 32'h00000013;

  if_stage dut (
    .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .Jump(Jump), .NewPC(NewPC),
    .PCNow(PCNow), .PCNext4(PCNext4), .IFID_Instruction(IFID_Instruction),
    .IFID_PC(IFID_PC), .IFID_PC4(IFID_PC4), .IFID_Valid(IFID_Valid),
    .MisalignedFault(MisalignedFault)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; PCWrite = 1'b1; Jump = 1'b0; NewPC = 64'd0;
    step(); step();
    check("rst_pc", PCNow, 64'd0);
    check("rst_valid", 64'(IFID_Valid), 64'd0);
    check("rst_instr", 64'(IFID_Instruction), 64'(NOP));
    check("rst_ifid_pc", IFID_PC, 64'd0);
    check("rst_fault", 64'(MisalignedFault), 64'd0);
    check("rst_next4", PCNext4, 64'd4);
    Reset = 1'b0;
    step();
    check("f0_ifid_pc", IFID_PC, 64'd0);
    check("f0_valid", 64'(IFID_Valid), 64'd1);
    check("f0_pc", PCNow, 64'd4);
    check("f0_instr", 64'(IFID_Instruction), 64'h00000093);
    check("f0_pc4", IFID_PC4, 64'd4);
    step();
    check("f1_ifid_pc", IFID_PC, 64'd4);
    check("f1_instr", 64'(IFID_Instruction), 64'h00100093);
    check("f1_pc", PCNow, 64'd8);
    check("f1_next4", PCNext4, 64'd12);
    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", PCNow, 64'd8);
      check("stall_ifid_pc", IFID_PC, 64'd4);
      check("stall_instr", 64'(IFID_Instruction), 64'h00100093);
      check("stall_valid", 64'(IFID_Valid), 64'd1);
    end
    PCWrite = 1'b1;
    step();
    check("resume_ifid_pc", IFID_PC, 64'd8);
    check("resume_instr", 64'(IFID_Instruction), 64'h00200093);
    check("resume_pc", PCNow, 64'd12);
    Jump = 1'b1; NewPC = 64'h20; PCWrite = 1'b0;
    step();
    check("jmp_pc", PCNow, 64'h20);
    check("jmp_valid", 64'(IFID_Valid), 64'd0);
    check("jmp_instr", 64'(IFID_Instruction), 64'(NOP));
    check("jmp_ifid_pc", IFID_PC, 64'd0);
    check("jmp_ifid_pc4", IFID_PC4, 64'd0);
    check("jmp_fault", 64'(MisalignedFault), 64'd0);
    Jump = 1'b0; PCWrite = 1'b1;
    step();
    check("tgt_ifid_pc", IFID_PC, 64'h20);
    check("tgt_ifid_pc4", IFID_PC4, 64'h24);
    check("tgt_valid", 64'(IFID_Valid), 64'd1);
    check("tgt_instr", 64'(IFID_Instruction), 64'h00800093);
    check("tgt_pc", PCNow, 64'h24);
    Jump = 1'b1; NewPC = 64'h102;
    step();
    check("mis_pc", PCNow, 64'h100);
    check("mis_fault", 64'(MisalignedFault), 64'd1);
    check("mis_valid", 64'(IFID_Valid), 64'd0);
    Jump = 1'b0;
    step();
    check("oor_instr", 64'(IFID_Instruction), 64'(NOP));
    check("oor_valid", 64'(IFID_Valid), 64'd1);
    check("oor_ifid_pc", IFID_PC, 64'h100);
    check("oor_fault_sticky", 64'(MisalignedFault), 64'd1);
    check("oor_pc", PCNow, 64'h104);
    Jump = 1'b1; NewPC = 64'h8;
    step();
    check("b2b1_pc", PCNow, 64'h8);
    NewPC = 64'h10;
    step();
    check("b2b2_pc", PCNow, 64'h10);
    check("b2b2_valid", 64'(IFID_Valid), 64'd0);
    check("b2b2_fault", 64'(MisalignedFault), 64'd1);
    Jump = 1'b0; PCWrite = 1'b0;
    step();
    check("hold_pc", PCNow, 64'h10);
    #2 Reset = 1'b1;
    #1;
    check("arst_pc", PCNow, 64'd0);
    check("arst_valid", 64'(IFID_Valid), 64'd0);
    check("arst_fault", 64'(MisalignedFault), 64'd0);
    check("arst_instr", 64'(IFID_Instruction), 64'(NOP));
    Reset = 1'b0; PCWrite = 1'b1;
    step();
    check("post_rst_ifid_pc", IFID_PC, 64'd0);
    check("post_rst_instr", 64'(IFID_Instruction), 64'h00000093);
    check("post_rst_pc", PCNow, 64'd4);
    Jump = 1'b1; NewPC = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("wrap_pc", PCNow, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next4", PCNext4, 64'd0);
    Jump = 1'b0;
    step();
    check("wrap_pc_after", PCNow, 64'd0);
    check("wrap_ifid_pc4", IFID_PC4, 64'd0);
    check("wrap_instr", 64'(IFID_Instruction), 64'(NOP));
    check("wrap_fault", 64'(MisalignedFault), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
